// File: rtl/mult_term_sequencer_if.sv
// rtl/mult_term_sequencer_if.sv - control/accumulator-side bundle of the shift-add term sequencer.
interface mult_term_sequencer_if #(
   parameter int XW = 12,
   parameter int NB = 6,
   parameter int PW = 6
);
   logic          start;
   logic [XW-1:0] x;
   logic [NB-1:0] y;
   logic          pause;
   logic          busy;
   logic          done;
   logic          init_result;
   logic          ldresult;
   logic [XW-1:0] one_bit_mult_x;
   logic [PW-1:0] powercnt;

   // master is the sequencer itself; slave is the controller/accumulator side.
   modport master (
      input  start, x, y, pause,
      output busy, done, init_result, ldresult, one_bit_mult_x, powercnt
   );

   modport slave (
      output start, x, y, pause,
      input  busy, done, init_result, ldresult, one_bit_mult_x, powercnt
   );
endinterface

// File: rtl/mult_term_sequencer.sv
// rtl/mult_term_sequencer.sv - serialises x*y into one gated, power-of-two weighted term per cycle.
module mult_term_sequencer #(
   parameter int XW = 12,
   parameter int NB = 6,
   parameter int PW = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   mult_term_sequencer_if.master bus
);
   localparam int IW = $clog2(NB + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NB);

   if (PW < NB) begin : g_pw_check
      $error("mult_term_sequencer: PW must be >= NB");
   end

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_TERM, S_DONE} state_t;

   state_t        r_state;
   logic [XW-1:0] r_x;
   logic [NB-1:0] r_y;
   logic [IW-1:0] r_idx;
   logic          r_busy;
   logic          r_done;
   logic          r_init;
   logic          r_ld;
   logic [XW-1:0] r_obx;
   logic [PW-1:0] r_pc;

   logic [XW-1:0] w_term;
   logic [PW-1:0] w_weight;

   // r_idx is the index of the next term to present, so it reaches NB once all terms are out.
   assign w_term   = r_y[r_idx] ? r_x : '0;
   assign w_weight = PW'(1) << r_idx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_init  <= 1'b0;
         r_ld    <= 1'b0;
         r_obx   <= '0;
         r_pc    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_x     <= bus.x;
                  r_y     <= bus.y;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_init  <= 1'b1;
                  r_state <= S_INIT;
               end
            end
            S_INIT: begin
               r_init  <= 1'b0;
               r_obx   <= w_term;
               r_pc    <= w_weight;
               r_ld    <= 1'b1;
               r_idx   <= r_idx + IW'(1);
               r_state <= S_TERM;
            end
            S_TERM: begin
               // A paused edge keeps the last term on the bus but withdraws ldresult.
               if (bus.pause) begin
                  r_ld <= 1'b0;
               end else if (r_idx == LAST_IDX) begin
                  r_ld    <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_obx <= w_term;
                  r_pc  <= w_weight;
                  r_ld  <= 1'b1;
                  r_idx <= r_idx + IW'(1);
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy           = r_busy;
   assign bus.done           = r_done;
   assign bus.init_result    = r_init;
   assign bus.ldresult       = r_ld;
   assign bus.one_bit_mult_x = r_obx;
   assign bus.powercnt       = r_pc;
endmodule

// File: tb/tb_mult_term_sequencer.sv
// tb/tb_mult_term_sequencer.sv - scoreboard bench for mult_term_sequencer with a reference term model.
module tb_mult_term_sequencer;
   localparam int XW = 12;
   localparam int NB = 6;
   localparam int PW = 6;

   typedef struct {
      longint x;
      longint y;
      int     k;
      int     done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;

   mult_term_sequencer_if #(.XW(XW), .NB(NB), .PW(PW)) bus ();

   mult_term_sequencer #(.XW(XW), .NB(NB), .PW(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   exp_t   sb[$];
   exp_t   cur;
   bit     active = 1'b0;
   int     terms;
   longint sum;
   longint prev_t, prev_w;
   int     n_checks = 0;
   int     n_fail = 0;
   int     n_done = 0;
   int     n_exp_done = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Monitor: pops the expectation on init_result and checks every presented term against it.
   always @(negedge clk) begin
      if (!rst) begin
         chk("reset_outputs", {bus.busy, bus.done, bus.init_result, bus.ldresult,
                               bus.one_bit_mult_x, bus.powercnt}, 0);
         active = 1'b0;
      end else begin
         if (bus.init_result) begin
            if (active) begin
               chk("init_during_sequence", bus.init_result, 0);
            end else if (sb.size() == 0) begin
               chk("unexpected_init", bus.init_result, 0);
            end else begin
               cur    = sb.pop_front();
               active = 1'b1;
               terms  = 0;
               sum    = 0;
               chk("init_cycle", cyc, cur.k + 1);
            end
         end
         chk("busy", bus.busy, active);
         if (bus.ldresult) begin
            if (!active || terms >= NB) begin
               chk("term_outside_sequence", terms + 1, NB);
            end else begin
               chk("term_value", bus.one_bit_mult_x, ((cur.y >> terms) & 1) != 0 ? cur.x : 0);
               chk("term_weight", bus.powercnt, longint'(1) << terms);
               sum    += longint'(bus.one_bit_mult_x) * longint'(bus.powercnt);
               prev_t = bus.one_bit_mult_x;
               prev_w = bus.powercnt;
               terms++;
            end
         end else if (active && terms > 0 && !bus.done) begin
            chk("held_term", bus.one_bit_mult_x, prev_t);
            chk("held_weight", bus.powercnt, prev_w);
         end
         if (bus.done) begin
            if (!active) begin
               chk("done_without_sequence", bus.done, 0);
            end else begin
               chk("term_count", terms, NB);
               chk("exact_product", sum, cur.x * cur.y);
               chk("acc_mod", sum % (longint'(1) << XW), (cur.x * cur.y) % (longint'(1) << XW));
               chk("done_cycle", cyc, cur.done_cyc);
               n_done++;
               active = 1'b0;
            end
         end
      end
   end

   // pmode: 0 no pause, 1 pause after term 1 for three cycles, 2 random pause.
   task automatic run_seq(input logic [XW-1:0] xv, input logic [NB-1:0] yv, input int pmode,
                          input bit do_abort, input bit do_restart);
      bit   pv[64];
      int   zeros;
      int   dj;
      exp_t e;
      for (int j = 0; j < 64; j++) begin
         if (pmode == 1)      pv[j] = (j >= 1 && j <= 3);
         else if (pmode == 2) pv[j] = (j < 40) && ($urandom_range(0, 3) == 0);
         else                 pv[j] = 1'b0;
      end
      // The NB-th cycle without pause in the term phase is the last one before done.
      zeros = 0;
      dj    = -1;
      for (int j = 0; j < 64; j++) begin
         if (!pv[j]) begin
            zeros++;
            if (zeros == NB && dj < 0) dj = j;
         end
      end
      e.x        = longint'(xv);
      e.y        = longint'(yv);
      e.k        = cyc;
      e.done_cyc = cyc + 2 + dj + 1;
      sb.push_back(e);
      if (!do_abort) n_exp_done++;
      bus.start = 1'b1;
      bus.x     = xv;
      bus.y     = yv;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.x     = XW'($urandom);
      bus.y     = NB'($urandom);
      bus.pause = 1'($urandom_range(0, 1));
      for (int c = e.k + 2; c <= e.done_cyc; c++) begin
         @(posedge clk); #1;
         bus.pause = (c < e.done_cyc) ? pv[c - e.k - 2] : 1'($urandom_range(0, 1));
         if (do_restart && (c == e.k + 4 || c == e.done_cyc)) begin
            bus.start = 1'b1;
            bus.x     = XW'($urandom);
            bus.y     = NB'($urandom);
         end else begin
            bus.start = 1'b0;
         end
         if (do_abort && c == e.k + 5) begin
            rst       = 1'b0;
            bus.start = 1'b0;
            bus.pause = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
            return;
         end
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.pause = 1'b0;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int wait_cyc;
      bus.start = 1'b0;
      bus.x     = '0;
      bus.y     = '0;
      bus.pause = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      gap(2);
      run_seq(12'd5, 6'd6, 0, 0, 0);
      gap(1);
      run_seq(12'd4095, 6'd63, 0, 0, 0);
      gap(2);
      run_seq(12'd7, 6'd5, 1, 0, 0);
      gap(1);
      run_seq(12'd9, 6'd43, 0, 0, 1);
      gap(2);
      run_seq(12'd200, 6'd45, 0, 1, 0);
      gap(1);
      run_seq(12'd3, 6'd2, 0, 0, 0);
      run_seq(12'd100, 6'd0, 0, 0, 0);
      for (int n = 0; n < 30; n++) begin
         gap($urandom_range(0, 3));
         run_seq(XW'($urandom), NB'($urandom), $urandom_range(0, 1) * 2, 0, ($urandom_range(0, 3) == 0));
      end
      wait_cyc = 0;
      while ((sb.size() != 0 || active) && wait_cyc < 100) begin
         @(posedge clk);
         wait_cyc++;
      end
      #1;
      chk("drain_pending", sb.size() + int'(active), 0);
      chk("completed_sequences", n_done, n_exp_done);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
